// File: rtl/ttl_74193.sv
// 74LS193-style synchronous 4-bit up/down counter with edge-detected count pins.
// Define TTL_74193_SYNC_CARRY_EN to register CO_n/BO_n instead of driving them combinationally.
module ttl_74193 (
    input  logic CLK,
    input  logic RST,
    input  logic UP,
    input  logic DOWN,
    input  logic LOAD_n,
    input  logic CLR,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic QA,
    output logic QB,
    output logic QC,
    output logic QD,
    output logic CO_n,
    output logic BO_n
);

    logic [3:0] q;
    logic [3:0] q_next;
    logic       up_prev;
    logic       dn_prev;
    logic       up_rise;
    logic       dn_rise;

    assign up_rise = UP & ~up_prev;
    assign dn_rise = DOWN & ~dn_prev;

    // A rise only counts while the opposite pin idles high
    always_comb begin
        q_next = q;
        if (RST || CLR) begin
            q_next = 4'd0;
        end else if (!LOAD_n) begin
            q_next = {D, C, B, A};
        end else if (up_rise && DOWN && !dn_rise) begin
            q_next = q + 4'd1;
        end else if (dn_rise && UP && !up_rise) begin
            q_next = q - 4'd1;
        end
    end

    // Edge registers track the pins every cycle so edges during clear/load are consumed
    always_ff @(posedge CLK) begin
        up_prev <= UP;
        dn_prev <= DOWN;
        q       <= q_next;
    end

    assign {QD, QC, QB, QA} = q;

`ifdef TTL_74193_SYNC_CARRY_EN
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            CO_n <= 1'b1;
            BO_n <= 1'b1;
        end else begin
            CO_n <= ~((q_next == 4'd15) & ~UP);
            BO_n <= ~((q_next == 4'd0) & ~DOWN);
        end
    end
`else
    assign CO_n = ~((q == 4'd15) & ~UP);
    assign BO_n = ~((q == 4'd0) & ~DOWN);
`endif

endmodule

// File: tb/tb_ttl_74193.sv
// Scoreboard bench for ttl_74193: random and directed pin activity against a count model,
// plus a two-stage cascade driven through CO_n/BO_n.
module tb_ttl_74193;

    typedef struct packed {
        logic [3:0] q;
        logic       co_n;
        logic       bo_n;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up = 1'b1;
    logic down = 1'b1;
    logic load_n = 1'b1;
    logic clr = 1'b0;
    logic da = 1'b0, db = 1'b0, dc = 1'b0, dd = 1'b0;

    logic qa0, qb0, qc0, qd0, co0, bo0;
    logic qa1, qb1, qc1, qd1, co1, bo1;

    int tests = 0;
    int fails = 0;

    exp_t sb[$];

    int m_cnt = 0;
    bit m_pu = 1'b1;
    bit m_pd = 1'b1;

    always #5 clk = ~clk;

    ttl_74193 u0 (
        .CLK(clk), .RST(rst), .UP(up), .DOWN(down),
        .LOAD_n(load_n), .CLR(clr),
        .A(da), .B(db), .C(dc), .D(dd),
        .QA(qa0), .QB(qb0), .QC(qc0), .QD(qd0),
        .CO_n(co0), .BO_n(bo0)
    );

    ttl_74193 u1 (
        .CLK(clk), .RST(rst), .UP(co0), .DOWN(bo0),
        .LOAD_n(1'b1), .CLR(1'b0),
        .A(1'b0), .B(1'b0), .C(1'b0), .D(1'b0),
        .QA(qa1), .QB(qb1), .QC(qc1), .QD(qd1),
        .CO_n(co1), .BO_n(bo1)
    );

    // Reference: integer count with modular arithmetic, pins judged by their previous level
    task automatic model(input bit r, input bit u, input bit dn,
                         input bit ln, input bit c, input int d);
        bit ur;
        bit dr;
        exp_t e;
        ur = u && !m_pu;
        dr = dn && !m_pd;
        if (r || c)
            m_cnt = 0;
        else if (!ln)
            m_cnt = d;
        else if (ur && dn && !dr)
            m_cnt = (m_cnt + 1) % 16;
        else if (dr && u && !ur)
            m_cnt = (m_cnt + 15) % 16;
        m_pu = u;
        m_pd = dn;
        e.q = m_cnt[3:0];
        e.co_n = !(m_cnt == 15 && !u);
        e.bo_n = !(m_cnt == 0 && !dn);
`ifdef TTL_74193_SYNC_CARRY_EN
        if (r || c) begin
            e.co_n = 1'b1;
            e.bo_n = 1'b1;
        end
`endif
        sb.push_back(e);
    endtask

    task automatic step(input bit r, input bit u, input bit dn,
                        input bit ln, input bit c, input int d);
        logic [3:0] dv;
        @(negedge clk);
        dv = d[3:0];
        rst = r;
        up = u;
        down = dn;
        load_n = ln;
        clr = c;
        {dd, dc, db, da} = dv;
        @(posedge clk);
        model(r, u, dn, ln, c, d);
    endtask

    task automatic up_pulse();
        step(0, 0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0);
    endtask

    // Monitor: one expected response per clock, compared after the edge settles
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {qd0, qc0, qb0, qa0, co0, bo0};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL sb t=%0t got q=%0d co_n=%b bo_n=%b want q=%0d co_n=%b bo_n=%b",
                             $time, a.q, a.co_n, a.bo_n, e.q, e.co_n, e.bo_n);
                end
            end
        end
    end

    task automatic check_val(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        int budget;
        step(1, 1, 1, 1, 0, 0);
        repeat (3) step(0, 1, 1, 1, 0, 0);

        step(0, 1, 1, 0, 0, 10);
        step(0, 1, 1, 1, 0, 0);
        repeat (6) up_pulse();

        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0);

        step(0, 0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 1, 5);
        step(0, 1, 1, 1, 0, 0);

        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0);

        step(0, 1, 1, 0, 0, 15);
        step(0, 0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0);

        for (int i = 0; i < 400; i++) begin
            int p;
            bit r;
            bit c;
            bit ln;
            p = $urandom_range(0, 99);
            r = (p < 2);
            c = (p >= 2 && p < 6);
            ln = !(p >= 6 && p < 13);
            step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 ln, c, $urandom_range(0, 15));
        end

        step(1, 1, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        repeat (20) up_pulse();
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        #2;
        check_val("cascade_low", int'({qd0, qc0, qb0, qa0}), 4);
        check_val("cascade_high", int'({qd1, qc1, qb1, qa1}), 1);

        budget = 10;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #3;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
